// File: rtl/simon_serial_ctrl.sv
// simon_serial_ctrl: byte-serial key/plaintext loader, round sequencer and ciphertext collector for a bit-serial SIMON 64/128 datapath.
// Defining SIMON_CTRL_ABORT_EN adds an abort input that cancels any operation in progress.
module simon_serial_ctrl #(
    parameter int NUM_ROUNDS  = 44,
    parameter int KEY_BYTES   = 16,
    parameter int BLOCK_BYTES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    input  logic       cipher_in,
    output logic       data_in,
    output logic [1:0] data_rdy,
    output logic [5:0] bit_counter,
    output logic       busy,
`ifdef SIMON_CTRL_ABORT_EN
    input  logic       abort,
`endif
    output logic       done
);
    localparam int KEY_BITS = KEY_BYTES * 8;
    localparam int PT_BITS  = BLOCK_BYTES * 8;

    typedef enum logic [2:0] {IDLE, LOAD_KEY, LOAD_PT, RUN, READOUT} state_t;
    state_t state;

    logic [7:0]  buf_q, col, col_shift, col_bytes, out_bytes;
    logic [2:0]  buf_idx, col_idx;
    logic [15:0] load_cnt;
    logic [6:0]  round_cnt;
    logic        buf_full, col_full, clr;
    logic        loading, shifting, last_bit, key_end, pt_end, accept, sampling, out_free, run_end;

`ifdef SIMON_CTRL_ABORT_EN
    assign clr = !reset || (abort && state != IDLE);
`else
    assign clr = !reset;
`endif

    assign loading   = state == LOAD_KEY || state == LOAD_PT;
    assign shifting  = loading && buf_full;
    assign last_bit  = shifting && buf_idx == 3'd7;
    assign key_end   = shifting && state == LOAD_KEY && load_cnt == 16'(KEY_BITS - 1);
    assign pt_end    = shifting && state == LOAD_PT && load_cnt == 16'(PT_BITS - 1);
    // the final plaintext bit cycle must not accept a byte: nothing would consume it
    assign in_ready  = loading && (!buf_full || (last_bit && !pt_end));
    assign accept    = in_valid && in_ready;
    assign sampling  = state == READOUT && !col_full && col_bytes != 8'(BLOCK_BYTES);
    assign col_shift = {cipher_in, col[7:1]};
    assign out_free  = !out_valid || out_ready;
    assign run_end   = state == RUN && round_cnt == 7'(NUM_ROUNDS - 1) && bit_counter == 6'd63;
    assign data_in   = shifting && buf_q[0];
    assign data_rdy  = state == RUN ? 2'd3 :
                       (state == LOAD_KEY && buf_full) ? 2'd2 :
                       (shifting || sampling) ? 2'd1 : 2'd0;

    always_ff @(posedge clk) begin
        if (clr) begin
            state       <= IDLE;
            buf_q       <= '0;
            buf_idx     <= '0;
            buf_full    <= 1'b0;
            load_cnt    <= '0;
            round_cnt   <= '0;
            col         <= '0;
            col_idx     <= '0;
            col_full    <= 1'b0;
            col_bytes   <= '0;
            out_bytes   <= '0;
            bit_counter <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= LOAD_KEY;
                        busy        <= 1'b1;
                        bit_counter <= '0;
                        load_cnt    <= '0;
                        buf_full    <= 1'b0;
                    end
                end
                LOAD_KEY, LOAD_PT: begin
                    if (shifting) begin
                        buf_q       <= buf_q >> 1;
                        buf_idx     <= buf_idx + 3'd1;
                        bit_counter <= bit_counter + 6'd1;
                        load_cnt    <= load_cnt + 16'd1;
                    end
                    if (accept) begin
                        buf_q    <= in_data;
                        buf_full <= 1'b1;
                        buf_idx  <= '0;
                    end else if (last_bit) begin
                        buf_full <= 1'b0;
                    end
                    // a byte accepted on the last key bit stays buffered as plaintext
                    if (key_end) begin
                        state       <= LOAD_PT;
                        bit_counter <= '0;
                        load_cnt    <= '0;
                    end
                    if (pt_end) begin
                        state       <= RUN;
                        bit_counter <= '0;
                        round_cnt   <= '0;
                    end
                end
                RUN: begin
                    bit_counter <= bit_counter + 6'd1;
                    if (bit_counter == 6'd63) round_cnt <= round_cnt + 7'd1;
                    if (run_end) begin
                        state       <= READOUT;
                        bit_counter <= '0;
                        col_idx     <= '0;
                        col_full    <= 1'b0;
                        col_bytes   <= '0;
                        out_bytes   <= '0;
                    end
                end
                READOUT: begin
                    if (sampling) begin
                        col         <= col_shift;
                        col_idx     <= col_idx + 3'd1;
                        bit_counter <= bit_counter + 6'd1;
                    end
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        out_bytes <= out_bytes + 8'd1;
                    end
                    // a full collector waits in place until the output register frees up
                    if (sampling && col_idx == 3'd7) begin
                        if (out_free) begin
                            out_data  <= col_shift;
                            out_valid <= 1'b1;
                            col_bytes <= col_bytes + 8'd1;
                        end else begin
                            col_full <= 1'b1;
                        end
                    end else if (col_full && out_ready) begin
                        out_data  <= col;
                        out_valid <= 1'b1;
                        col_full  <= 1'b0;
                        col_bytes <= col_bytes + 8'd1;
                    end
                    if (out_valid && out_ready && out_bytes == 8'(BLOCK_BYTES - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/simon_serial_ctrl.md
SIMON_SERIAL_CTRL -- requirements
Module: simon_serial_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- NUM_ROUNDS, 44, encryption rounds per block.
- KEY_BYTES, 16, key length in bytes (128 bits).
- BLOCK_BYTES, 8, block length in bytes (64 bits).
REQ-002 Ports (name direction width meaning), one per line:
- clk in 1: clock.
- reset in 1: synchronous, active-low.
- start in 1: begin one encryption.
- in_data in 8: key/plaintext byte, LSB first.
- in_valid in 1: in_data valid.
- in_ready out 1: controller accepts in_data.
- out_data out 8: ciphertext byte.
- out_valid out 1: out_data valid.
- out_ready in 1: sink accepts out_data.
- cipher_in in 1: serial ciphertext bit from datapath.
- data_in out 1: serial bit to datapath.
- data_rdy out 2: datapath mode (0 hold, 1 block shift, 2 key load, 3 run).
- bit_counter out 6: bit position within the current 64-bit word.
- busy out 1: operation in progress.
- done out 1: one-cycle completion pulse.
- abort in 1: cancel (present only with SIMON_CTRL_ABORT_EN).

Function
REQ-003 The FSM SHALL have states IDLE, LOAD_KEY, LOAD_PT, RUN, READOUT; data_rdy is 0 in IDLE.
REQ-004 In IDLE, start=1 SHALL move to LOAD_KEY next cycle with busy=1; start SHALL be ignored when not IDLE.
REQ-005 The load states SHALL hold an 8-bit buffer; in_ready=1 when the buffer is empty or on its 8th bit cycle; a byte is accepted on in_valid&&in_ready.
REQ-006 Each accepted byte SHALL drive data_in with bits 0..7 on the 8 following cycles, with data_rdy=2 (LOAD_KEY) or 1 (LOAD_PT); with the buffer empty, data_rdy SHALL be 0 and bit_counter held.
REQ-007 After KEY_BYTES*8 key bits, the FSM SHALL enter LOAD_PT seamlessly (a byte accepted on the last key bit cycle is plaintext); after BLOCK_BYTES*8 bits, it SHALL enter RUN.
REQ-008 bit_counter SHALL increment mod 64 on every cycle with data_rdy!=0 and reset to 0 on every state entry.
REQ-009 RUN SHALL drive data_rdy=3 for exactly NUM_ROUNDS*64 consecutive cycles, with no stalls, using an internal 7-bit round count; data_in=0.
REQ-010 READOUT SHALL drive data_rdy=1, sampling cipher_in into a collector LSB first; on 8 collected bits, the collector SHALL transfer to the out_data register, asserting out_valid next cycle.
REQ-011 When out_valid=1 and out_ready=0 on the cycle the collector completes, READOUT SHALL stall: data_rdy=0, bit_counter held, no sampling.
REQ-012 out_data and out_valid SHALL hold until out_ready; a simultaneous accept and new transfer SHALL keep out_valid=1 with new data.
REQ-013 After the BLOCK_BYTES-th output byte is accepted, done SHALL pulse 1 cycle later, busy SHALL fall, and the FSM SHALL enter IDLE.

Reset
REQ-014 reset=0 at a clock edge SHALL force IDLE, buffers and counters 0, all outputs 0, including mid-operation.

Configuration
REQ-015 With SIMON_CTRL_ABORT_EN defined, abort=1 in any non-IDLE state SHALL enter IDLE next cycle, with outputs as after reset and no done pulse; without it, the abort port and logic SHALL be absent.

Verification
REQ-016 Take cycle 0 as start accepted, with in_valid=1 and out_ready=1 throughout -> key bits on cycles 2..129, plaintext bits 130..193, data_rdy=3 on cycles 194..3009, first out_valid on 3018, done on 3075.
REQ-017 Deassert in_valid for 5 cycles mid-key -> data_rdy=0 and bit_counter frozen for those cycles; data_in sequence unchanged.
REQ-018 Hold out_ready=0 through all of READOUT -> data_rdy=0 stall after the second byte collects; out_data byte 0 stable; no bits lost after release.
REQ-019 Sequences:
- start pulsed during RUN -> no effect.
- reset=0 at cycle 1000 -> all outputs 0 next cycle, then a new start completes normally.
REQ-020 With SIMON_CTRL_ABORT_EN, abort during READOUT -> IDLE next cycle, done stays 0, busy=0.
